cp0_except_ctrl: RTL and testbench
==================================

// Module: cp0_except_ctrl
// PURPOSE
//  Exception commit controller plus CP0 subset (BadVAddr, Count, Compare, Status, Cause, EPC).
//  Sits at the MEM/WB boundary and consumes the 32-bit excepttype code from the exception detector.
//  On an accepted exception or ERET it updates CP0 and issues a one-cycle pipeline flush with a redirect PC.
//  It then drains for a fixed number of cycles. It also provides the MTC0/MFC0 register port and the Count/Compare timer interrupt.
// PARAMETERS
//  EXC_VECTOR   32'hBFC0_0380  redirect target for every exception except ERET
//  DRAIN_CYC    2              cycles after flush during which new excepttype is ignored (>=1)
//  STATUS_RST   32'h0040_0000  Status reset value (BEV=1)
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  excepttype_i  in   32  code from detector: 01 Int, 04 AdEL, 05 AdES, 08 Sys, 09 Bp, 0a RI, 0c Ov, 0e ERET, 0 none
//  pc_m_i        in   32  PC of the MEM-stage instruction
//  in_dslot_m_i  in   1   MEM-stage instruction sits in a branch delay slot
//  bad_addr_m_i  in   32  faulting address (PC or data address) for AdEL/AdES
//  stall_m_i     in   1   MEM stage stalled; nothing is accepted while high
//  we_i          in   1   MTC0 write strobe
//  waddr_i       in   5   MTC0 register number
//  wdata_i       in   32  MTC0 data
//  raddr_i       in   5   MFC0 register number
//  rdata_o       out  32  MFC0 data, combinational from current registers; unmapped -> 0
//  int_i         in   6   external hardware interrupts, level
//  status_o      out  32  Status, to the exception detector
//  cause_o       out  32  Cause, to the exception detector
//  epc_o         out  32  EPC
//  flush_o       out  1   flush all stages, one cycle
//  newpc_o       out  32  redirect PC, valid only while flush_o=1
//  timer_int_o   out  1   Count==Compare pending (Cause.IP7 source)
// BEHAVIOUR
//  Reset: state IDLE; flush_o=0; newpc_o=0; Status=STATUS_RST; all other registers 0; timer_int_o=0.
//  FSM IDLE -> FLUSH -> DRAIN -> IDLE.
//   - IDLE: accept when excepttype_i!=0 && !stall_m_i. CP0 updates on that edge. Next state FLUSH.
//   - FLUSH: flush_o=1 for exactly 1 cycle; newpc_o = EPC if ERET, else EXC_VECTOR. Next state DRAIN.
//   - DRAIN: counter runs DRAIN_CYC cycles, excepttype_i ignored, then IDLE. MTC0 is still honoured.
//  Accept actions for any code other than 0e:
//   - EPC = in_dslot_m_i ? pc_m_i-4 : pc_m_i; Cause.BD(31) = in_dslot_m_i.
//   - Cause.ExcCode[6:2] = excepttype_i[4:0], with Int -> 0.
//   - Status.EXL(1) = 1.
//   - BadVAddr = bad_addr_m_i for AdEL/AdES only.
//  Accept action for ERET (0e): Status.EXL=0; Cause, EPC and BadVAddr unchanged.
//  Cause.IP[15:10] = {int_i[5]|timer_int_o, int_i[4:0]}, registered every cycle.
//  Cause.IP[9:8] and the writable Status bits are written only via MTC0.
//  MTC0 writable fields:
//   - Status: all bits.
//   - Cause: IP[9:8] only.
//   - EPC, Compare, Count: all bits.
//   - BadVAddr: read-only.
//  Writing Compare clears timer_int_o.
//  Count increments by 1 every second clk (internal toggle), wraps 0xFFFFFFFF -> 0.
//  timer_int_o sets when Count==Compare at an increment and holds until a Compare write.
//  Write to Count resets the toggle phase.
//  Simultaneous accept and MTC0 to the same register in one cycle: the exception update wins.
//  MTC0 to other registers in that cycle is still applied.
//  Simultaneous Compare write and match: the write wins, so timer_int_o=0.
//  Reset mid-FLUSH/DRAIN: immediate return to IDLE, flush_o drops asynchronously.
//  rdata_o reflects pre-edge register values; there is no write-to-read bypass.
// STRUCTURE
//  Package cp0_defs_pkg holds:
//   - CP0 register numbers: 8, 9, 11, 12, 13, 14.
//   - EXC_* codes (01, 04, 05, 08, 09, 0a, 0c, 0e).
//   - Status/Cause bit positions.
//   - FSM state encoding.
//  Sub-module cp0_timer: Count/Compare, the toggle divider and timer_int_o.
// TESTING
//  - Reset: rst=1 -> Status=0040_0000, flush_o=0, rdata_o(12)=0040_0000; Count holds 0.
//  - Ov, pc_m=8000_0100, dslot=0 -> next cycle flush_o=1, newpc=BFC0_0380; EPC=8000_0100; Cause[6:2]=0c; EXL=1.
//  - AdEL, dslot=1, pc=8000_0208, bad=8000_0001 -> EPC=8000_0204, BD=1, BadVAddr=8000_0001, ExcCode=04.
//  - ERET with EPC=8000_0300 -> flush_o=1, newpc=8000_0300, EXL=0; Cause unchanged.
//  - Back-to-back: Sys, then Bp during DRAIN -> Bp ignored, single flush pulse; Bp held past DRAIN -> second flush.
//  - Timer: write Compare=5, Count=0 -> timer_int_o=1 after 10 clk, Cause[15]=1 next cycle; Compare write -> 0.

Source files
------------

// File: rtl/cp0_defs_pkg.sv
// CP0 register map, exception codes, Status/Cause field positions and the
// commit-controller state encoding shared by the exception controller and its timer.
package cp0_defs_pkg;

   localparam logic [4:0] RegBadVAddr = 5'd8;
   localparam logic [4:0] RegCount    = 5'd9;
   localparam logic [4:0] RegCompare  = 5'd11;
   localparam logic [4:0] RegStatus   = 5'd12;
   localparam logic [4:0] RegCause    = 5'd13;
   localparam logic [4:0] RegEpc      = 5'd14;

   localparam logic [31:0] ExcInt  = 32'h0000_0001;
   localparam logic [31:0] ExcAdel = 32'h0000_0004;
   localparam logic [31:0] ExcAdes = 32'h0000_0005;
   localparam logic [31:0] ExcSys  = 32'h0000_0008;
   localparam logic [31:0] ExcBp   = 32'h0000_0009;
   localparam logic [31:0] ExcRi   = 32'h0000_000a;
   localparam logic [31:0] ExcOv   = 32'h0000_000c;
   localparam logic [31:0] ExcEret = 32'h0000_000e;

   localparam int unsigned StatusExl  = 1;
   localparam int unsigned CauseBd    = 31;
   localparam int unsigned CauseExcLo = 2;
   localparam int unsigned CauseExcHi = 6;
   localparam int unsigned CauseSwLo  = 8;
   localparam int unsigned CauseSwHi  = 9;
   localparam int unsigned CauseHwLo  = 10;
   localparam int unsigned CauseHwHi  = 15;

   typedef enum logic [1:0] {
      StIdle,
      StFlush,
      StDrain
   } exc_state_e;

endpackage

// File: rtl/cp0_except_ctrl_if.sv
// MTC0/MFC0 register port between the pipeline (master) and the CP0 block (slave).
interface cp0_except_ctrl_if;

   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  raddr;
   logic [31:0] rdata;

   modport master (output we, waddr, wdata, raddr, input rdata);
   modport slave  (input we, waddr, wdata, raddr, output rdata);

endinterface

// File: rtl/cp0_timer.sv
// CP0 Count/Compare pair: Count advances every second clock and raises a sticky
// timer interrupt on reaching Compare; a Compare write acknowledges it.
module cp0_timer (
   input  logic        clk,
   input  logic        rst,
   input  logic        count_we_i,
   input  logic        compare_we_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        timer_int_o
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        phase_q, phase_d;
   logic        timer_int_q, timer_int_d;

   always_comb begin
      count_d     = count_q;
      compare_d   = compare_q;
      phase_d     = ~phase_q;
      timer_int_d = timer_int_q;
      if (count_we_i) begin
         count_d = wdata_i;
         phase_d = 1'b0;
      end else if (phase_q) begin
         count_d = count_q + 32'd1;
         if (count_d == compare_q) timer_int_d = 1'b1;
      end
      // Acknowledge beats a coincident match.
      if (compare_we_i) begin
         compare_d   = wdata_i;
         timer_int_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q     <= 32'd0;
         compare_q   <= 32'd0;
         phase_q     <= 1'b0;
         timer_int_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         compare_q   <= compare_d;
         phase_q     <= phase_d;
         timer_int_q <= timer_int_d;
      end
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_except_ctrl.sv
// Exception commit controller at MEM/WB: updates CP0 on an accepted exception or
// ERET, pulses a one-cycle flush with a redirect PC, then drains before accepting again.
module cp0_except_ctrl
   import cp0_defs_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter int unsigned DRAIN_CYC  = 2,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        excepttype_i,
   input  logic [31:0]        pc_m_i,
   input  logic               in_dslot_m_i,
   input  logic [31:0]        bad_addr_m_i,
   input  logic               stall_m_i,
   cp0_except_ctrl_if.slave   reg_bus,
   input  logic [5:0]         int_i,
   output logic [31:0]        status_o,
   output logic [31:0]        cause_o,
   output logic [31:0]        epc_o,
   output logic               flush_o,
   output logic [31:0]        newpc_o,
   output logic               timer_int_o
);

   localparam int unsigned CntW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   exc_state_e      state_q, state_d;
   logic [CntW-1:0] drain_q, drain_d;
   logic            eret_q, eret_d;
   logic [31:0]     status_q, status_d, cause_q, cause_d;
   logic [31:0]     epc_q, epc_d, badvaddr_q, badvaddr_d;
   logic [31:0]     count, compare;
   logic            accept, is_eret, is_addr_exc;
   logic            wr_status, wr_cause, wr_epc, wr_count, wr_compare;

   assign accept      = (state_q == StIdle) && (excepttype_i != 32'd0) && !stall_m_i;
   assign is_eret     = (excepttype_i == ExcEret);
   assign is_addr_exc = (excepttype_i == ExcAdel) || (excepttype_i == ExcAdes);

   assign wr_status  = reg_bus.we && (reg_bus.waddr == RegStatus);
   assign wr_cause   = reg_bus.we && (reg_bus.waddr == RegCause);
   assign wr_epc     = reg_bus.we && (reg_bus.waddr == RegEpc);
   assign wr_count   = reg_bus.we && (reg_bus.waddr == RegCount);
   assign wr_compare = reg_bus.we && (reg_bus.waddr == RegCompare);

   cp0_timer u_timer (
      .clk          (clk),
      .rst          (rst),
      .count_we_i   (wr_count),
      .compare_we_i (wr_compare),
      .wdata_i      (reg_bus.wdata),
      .count_o      (count),
      .compare_o    (compare),
      .timer_int_o  (timer_int_o)
   );

   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      eret_d  = eret_q;
      flush_o = 1'b0;
      newpc_o = 32'd0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StFlush;
               eret_d  = is_eret;
            end
         end
         StFlush: begin
            flush_o = 1'b1;
            newpc_o = eret_q ? epc_q : EXC_VECTOR;
            state_d = StDrain;
            drain_d = '0;
         end
         StDrain: begin
            if (drain_q == CntW'(DRAIN_CYC - 1)) state_d = StIdle;
            else                                 drain_d = drain_q + CntW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   // MTC0 first; an accepted exception then overrides any register it owns.
   always_comb begin
      status_d   = status_q;
      cause_d    = cause_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      if (wr_status) status_d = reg_bus.wdata;
      if (wr_cause)  cause_d[CauseSwHi:CauseSwLo] = reg_bus.wdata[CauseSwHi:CauseSwLo];
      if (wr_epc)    epc_d = reg_bus.wdata;
      if (accept) begin
         status_d = status_q;
         if (is_eret) begin
            status_d[StatusExl] = 1'b0;
         end else begin
            status_d[StatusExl] = 1'b1;
            cause_d             = cause_q;
            cause_d[CauseBd]    = in_dslot_m_i;
            cause_d[CauseExcHi:CauseExcLo] = (excepttype_i == ExcInt) ? 5'd0 : excepttype_i[4:0];
            epc_d = in_dslot_m_i ? (pc_m_i - 32'd4) : pc_m_i;
            if (is_addr_exc) badvaddr_d = bad_addr_m_i;
         end
      end
      cause_d[CauseHwHi:CauseHwLo] = {int_i[5] | timer_int_o, int_i[4:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         drain_q    <= '0;
         eret_q     <= 1'b0;
         status_q   <= STATUS_RST;
         cause_q    <= 32'd0;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         drain_q    <= drain_d;
         eret_q     <= eret_d;
         status_q   <= status_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   always_comb begin
      reg_bus.rdata = 32'd0;
      case (reg_bus.raddr)
         RegBadVAddr: reg_bus.rdata = badvaddr_q;
         RegCount:    reg_bus.rdata = count;
         RegCompare:  reg_bus.rdata = compare;
         RegStatus:   reg_bus.rdata = status_q;
         RegCause:    reg_bus.rdata = cause_q;
         RegEpc:      reg_bus.rdata = epc_q;
         default:     reg_bus.rdata = 32'd0;
      endcase
   end

   assign status_o = status_q;
   assign cause_o  = cause_q;
   assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_except_ctrl.sv
// Directed bench for cp0_except_ctrl: exception commit, ERET, drain behaviour,
// MTC0 priority, interrupt sampling and the Count/Compare timer.
module tb_cp0_except_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] excepttype;
   logic [31:0] pc_m;
   logic        in_dslot;
   logic [31:0] bad_addr;
   logic        stall;
   logic [5:0]  int_in;
   logic [31:0] status_o, cause_o, epc_o, newpc_o;
   logic        flush_o, timer_int_o;

   int vectors    = 0;
   int miscompares = 0;

   cp0_except_ctrl_if rb ();

   cp0_except_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .excepttype_i (excepttype),
      .pc_m_i       (pc_m),
      .in_dslot_m_i (in_dslot),
      .bad_addr_m_i (bad_addr),
      .stall_m_i    (stall),
      .reg_bus      (rb),
      .int_i        (int_in),
      .status_o     (status_o),
      .cause_o      (cause_o),
      .epc_o        (epc_o),
      .flush_o      (flush_o),
      .newpc_o      (newpc_o),
      .timer_int_o  (timer_int_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one exception for a single accept edge, then withdraw it.
   task automatic commit(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                         input logic [31:0] bad);
      excepttype = code;
      pc_m       = pc;
      in_dslot   = ds;
      bad_addr   = bad;
      @(posedge clk);
      #1 excepttype = 32'd0;
   endtask

   task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
      rb.we    = 1'b1;
      rb.waddr = addr;
      rb.wdata = data;
      @(posedge clk);
      #1 rb.we = 1'b0;
   endtask

   // From the FLUSH-cycle negedge, three edges return the FSM to IDLE.
   task automatic settle();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      excepttype = 32'd0; pc_m = 32'd0; in_dslot = 1'b0; bad_addr = 32'd0;
      stall = 1'b0; int_in = 6'd0;
      rb.we = 1'b0; rb.waddr = 5'd0; rb.wdata = 32'd0; rb.raddr = 5'd12;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (status_o !== 32'h0040_0000) begin
         miscompares++; $display("FAIL reset_status: got %h want 00400000", status_o);
      end
      vectors++;
      if (flush_o !== 1'b0 || newpc_o !== 32'd0) begin
         miscompares++; $display("FAIL reset_flush: got %b/%h want 0/00000000", flush_o, newpc_o);
      end
      vectors++;
      if (rb.rdata !== 32'h0040_0000) begin
         miscompares++; $display("FAIL reset_rdata12: got %h want 00400000", rb.rdata);
      end
      rb.raddr = 5'd9;
      @(negedge clk);
      vectors++;
      if (rb.rdata !== 32'd0 || timer_int_o !== 1'b0) begin
         miscompares++; $display("FAIL reset_count: got %h/%b want 00000000/0", rb.rdata, timer_int_o);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_ov();
      commit(32'h0c, 32'h8000_0100, 1'b0, 32'd0);
      @(negedge clk);
      vectors++;
      if (flush_o !== 1'b1 || newpc_o !== 32'hBFC0_0380) begin
         miscompares++; $display("FAIL ov_flush: got %b/%h want 1/bfc00380", flush_o, newpc_o);
      end
      vectors++;
      if (epc_o !== 32'h8000_0100) begin
         miscompares++; $display("FAIL ov_epc: got %h want 80000100", epc_o);
      end
      vectors++;
      if (cause_o !== 32'h0000_0030) begin
         miscompares++; $display("FAIL ov_cause: got %h want 00000030", cause_o);
      end
      vectors++;
      if (status_o !== 32'h0040_0002) begin
         miscompares++; $display("FAIL ov_status: got %h want 00400002", status_o);
      end
      @(negedge clk);
      vectors++;
      if (flush_o !== 1'b0) begin
         miscompares++; $display("FAIL ov_single_pulse: got %b want 0", flush_o);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_adel();
      rb.raddr = 5'd8;
      commit(32'h04, 32'h8000_0208, 1'b1, 32'h8000_0001);
      @(negedge clk);
      vectors++;
      if (epc_o !== 32'h8000_0204) begin
         miscompares++; $display("FAIL adel_epc: got %h want 80000204", epc_o);
      end
      vectors++;
      if (cause_o !== 32'h8000_0010) begin
         miscompares++; $display("FAIL adel_cause: got %h want 80000010", cause_o);
      end
      vectors++;
      if (rb.rdata !== 32'h8000_0001) begin
         miscompares++; $display("FAIL adel_badvaddr: got %h want 80000001", rb.rdata);
      end
      settle();
   endtask

   task automatic test_eret();
      mtc0(5'd14, 32'h8000_0300);
      commit(32'h0e, 32'h8000_0500, 1'b0, 32'h1234_0000);
      @(negedge clk);
      vectors++;
      if (flush_o !== 1'b1 || newpc_o !== 32'h8000_0300) begin
         miscompares++; $display("FAIL eret_flush: got %b/%h want 1/80000300", flush_o, newpc_o);
      end
      vectors++;
      if (status_o !== 32'h0040_0000) begin
         miscompares++; $display("FAIL eret_status: got %h want 00400000", status_o);
      end
      vectors++;
      if (cause_o !== 32'h8000_0010 || epc_o !== 32'h8000_0300) begin
         miscompares++; $display("FAIL eret_unchanged: got %h/%h want 80000010/80000300", cause_o, epc_o);
      end
      settle();
   endtask

   task automatic test_stall();
      stall = 1'b1;
      excepttype = 32'h0a; pc_m = 32'h8000_0700; in_dslot = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vectors++;
         if (flush_o !== 1'b0) begin
            miscompares++; $display("FAIL stall_hold[%0d]: got %b want 0", i, flush_o);
         end
      end
      @(posedge clk);
      #1 stall = 1'b0;
      @(posedge clk);
      #1 excepttype = 32'd0;
      @(negedge clk);
      vectors++;
      if (flush_o !== 1'b1 || cause_o !== 32'h0000_0028) begin
         miscompares++; $display("FAIL stall_release: got %b/%h want 1/00000028", flush_o, cause_o);
      end
      settle();
   endtask

   task automatic test_back_to_back();
      logic exp_flush [5];
      exp_flush = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      commit(32'h08, 32'h8000_0400, 1'b0, 32'd0);
      excepttype = 32'h09; pc_m = 32'h8000_0410;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         vectors++;
         if (flush_o !== exp_flush[i]) begin
            miscompares++; $display("FAIL b2b_flush[%0d]: got %b want %b", i, flush_o, exp_flush[i]);
         end
         if (i == 0) begin
            vectors++;
            if (epc_o !== 32'h8000_0400 || cause_o !== 32'h0000_0020) begin
               miscompares++; $display("FAIL b2b_first: got %h/%h want 80000400/00000020", epc_o, cause_o);
            end
         end
      end
      excepttype = 32'd0;
      vectors++;
      if (epc_o !== 32'h8000_0410 || cause_o !== 32'h0000_0024) begin
         miscompares++; $display("FAIL b2b_second: got %h/%h want 80000410/00000024", epc_o, cause_o);
      end
      settle();
   endtask

   task automatic test_mtc0_conflict();
      rb.we = 1'b1; rb.waddr = 5'd14; rb.wdata = 32'h1234_5678;
      commit(32'h0c, 32'h8000_0600, 1'b0, 32'd0);
      rb.we = 1'b0;
      @(negedge clk);
      vectors++;
      if (epc_o !== 32'h8000_0600) begin
         miscompares++; $display("FAIL conflict_epc: got %h want 80000600", epc_o);
      end
      settle();
      rb.raddr = 5'd11;
      rb.we = 1'b1; rb.waddr = 5'd11; rb.wdata = 32'hFFFF_0000;
      commit(32'h0c, 32'h8000_0610, 1'b0, 32'd0);
      rb.we = 1'b0;
      @(negedge clk);
      vectors++;
      if (rb.rdata !== 32'hFFFF_0000 || epc_o !== 32'h8000_0610) begin
         miscompares++; $display("FAIL conflict_other: got %h/%h want ffff0000/80000610", rb.rdata, epc_o);
      end
      settle();
   endtask

   task automatic test_int();
      int_in = 6'b100101;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (cause_o[15:10] !== 6'b100101) begin
         miscompares++; $display("FAIL int_sample: got %b want 100101", cause_o[15:10]);
      end
      #1 int_in = 6'd0;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (cause_o[15:10] !== 6'b000000) begin
         miscompares++; $display("FAIL int_clear: got %b want 000000", cause_o[15:10]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_timer();
      rb.raddr = 5'd9;
      mtc0(5'd11, 32'd5);
      mtc0(5'd9, 32'd0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (timer_int_o !== 1'b0 || rb.rdata !== 32'd4) begin
         miscompares++; $display("FAIL timer_before: got %b/%h want 0/00000004", timer_int_o, rb.rdata);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (timer_int_o !== 1'b1 || rb.rdata !== 32'd5) begin
         miscompares++; $display("FAIL timer_set: got %b/%h want 1/00000005", timer_int_o, rb.rdata);
      end
      vectors++;
      if (cause_o[15] !== 1'b0) begin
         miscompares++; $display("FAIL timer_cause_lag: got %b want 0", cause_o[15]);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (cause_o[15] !== 1'b1 || timer_int_o !== 1'b1) begin
         miscompares++; $display("FAIL timer_cause: got %b/%b want 1/1", cause_o[15], timer_int_o);
      end
      #1;
      mtc0(5'd11, 32'd100);
      @(negedge clk);
      vectors++;
      if (timer_int_o !== 1'b0) begin
         miscompares++; $display("FAIL timer_ack: got %b want 0", timer_int_o);
      end
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (cause_o[15] !== 1'b0) begin
         miscompares++; $display("FAIL timer_cause_ack: got %b want 0", cause_o[15]);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_flush();
      commit(32'h08, 32'h8000_0800, 1'b0, 32'd0);
      #1;
      vectors++;
      if (flush_o !== 1'b1) begin
         miscompares++; $display("FAIL midflush_pre: got %b want 1", flush_o);
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (flush_o !== 1'b0 || newpc_o !== 32'd0 || status_o !== 32'h0040_0000) begin
         miscompares++;
         $display("FAIL midflush_async: got %b/%h/%h want 0/00000000/00400000",
                  flush_o, newpc_o, status_o);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (flush_o !== 1'b0) begin
         miscompares++; $display("FAIL midflush_idle: got %b want 0", flush_o);
      end
   endtask

   initial begin
      test_reset();
      test_ov();
      test_adel();
      test_eret();
      test_stall();
      test_back_to_back();
      test_mtc0_conflict();
      test_int();
      test_timer();
      test_reset_mid_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
